// File: rtl/tt_bist_harness.sv
// rtl/tt_bist_harness.sv - LFSR-stimulus / MISR-compaction self-test harness
module tt_bist_harness #(
    parameter int                WIDTH       = 8,
    parameter int                NUM_VECTORS = 256,
    parameter int                RESP_LAT    = 0,
    parameter logic [WIDTH-1:0]  SEED        = 8'h01,
    parameter logic [WIDTH-1:0]  LFSR_TAPS   = 8'hB8,
    parameter logic [WIDTH-1:0]  MISR_TAPS   = 8'hB8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic             start,
    input  logic [WIDTH-1:0] expected_sig,
    input  logic [WIDTH-1:0] dut_resp,
    output logic [WIDTH-1:0] stim_out,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [WIDTH-1:0] signature
);

    localparam int TOTAL = NUM_VECTORS + RESP_LAT;
    localparam int CNT_W = $clog2(TOTAL + 1);
    localparam logic [CNT_W-1:0] LAST_K = CNT_W'(TOTAL - 1);
    localparam logic [CNT_W-1:0] ONE_K  = CNT_W'(1);
    // An all-zero seed would lock the LFSR at zero forever.
    localparam logic [WIDTH-1:0] SEED_EFF = (SEED == '0) ? WIDTH'(1) : SEED;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] lfsr_q, lfsr_d;
    logic [WIDTH-1:0] misr_q, misr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             pass_q, pass_d;

    // State register; ena=0 is handled by next-state logic holding every value
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            lfsr_q  <= '0;
            misr_q  <= '0;
            cnt_q   <= '0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            lfsr_q  <= lfsr_d;
            misr_q  <= misr_d;
            cnt_q   <= cnt_d;
            pass_q  <= pass_d;
        end
    end

    // Next-state: seed on start, step LFSR/MISR each RUN cycle, latch verdict on entry to DONE
    always_comb begin
        state_d = state_q;
        lfsr_d  = lfsr_q;
        misr_d  = misr_q;
        cnt_d   = cnt_q;
        pass_d  = pass_q;
        if (ena) begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        lfsr_d  = SEED_EFF;
                        misr_d  = '0;
                        cnt_d   = '0;
                        pass_d  = 1'b0;
                        state_d = S_RUN;
                    end
                end
                S_RUN: begin
                    lfsr_d = {lfsr_q[WIDTH-2:0], ^(lfsr_q & LFSR_TAPS)};
                    // The first RESP_LAT cycles carry no valid response yet
                    if (int'(cnt_q) >= RESP_LAT) begin
                        misr_d = {misr_q[WIDTH-2:0], ^(misr_q & MISR_TAPS)} ^ dut_resp;
                    end
                    cnt_d = cnt_q + ONE_K;
                    if (cnt_q == LAST_K) begin
                        state_d = S_DONE;
                        pass_d  = (misr_d == expected_sig);
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Outputs derive from registered state only, so reset clears them immediately
    always_comb begin
        busy      = (state_q == S_RUN);
        done      = (state_q == S_DONE);
        pass      = pass_q;
        signature = misr_q;
        stim_out  = '0;
        if (state_q == S_RUN && int'(cnt_q) < NUM_VECTORS) begin
            stim_out = lfsr_q;
        end
    end

endmodule
